// File: rtl/ex_alu_iter_if.sv
// Operand/result bundle between the issue stage and the iterative EX ALU.
// The slave side is the ALU; the master side is whoever presents operations.
interface ex_alu_iter_if #(
    parameter int NB_DATA       = 32,
    parameter int NB_ALU_OPCODE = 4,
    parameter int NB_SHAMT      = 5
);
    logic                     i_valid;
    logic                     i_flush;
    logic [NB_ALU_OPCODE-1:0] i_alu_opcode;
    logic                     i_second_ope_sa;
    logic                     i_second_ope_rs;
    logic                     i_first_ope_rt;
    logic [NB_DATA-1:0]       i_rs_data;
    logic [NB_DATA-1:0]       i_rt_data;
    logic [NB_DATA-1:0]       i_imm;
    logic                     i_use_imm;
    logic [NB_SHAMT-1:0]      i_shamt;
    logic                     o_ready;
    logic                     o_valid;
    logic [NB_DATA-1:0]       o_result;
    logic                     o_zero;

    modport slave (
        input  i_valid, i_flush, i_alu_opcode, i_second_ope_sa, i_second_ope_rs,
               i_first_ope_rt, i_rs_data, i_rt_data, i_imm, i_use_imm, i_shamt,
        output o_ready, o_valid, o_result, o_zero
    );

    modport master (
        output i_valid, i_flush, i_alu_opcode, i_second_ope_sa, i_second_ope_rs,
               i_first_ope_rt, i_rs_data, i_rt_data, i_imm, i_use_imm, i_shamt,
        input  o_ready, o_valid, o_result, o_zero
    );
endinterface

// File: rtl/ex_alu_iter.sv
// EX-stage ALU with a one-bit-per-cycle shifter; non-shift ops and zero-amount
// shifts complete in one cycle, shifts by N take N+1 cycles.
module ex_alu_iter #(
    parameter int NB_DATA       = 32,
    parameter int NB_ALU_OPCODE = 4,
    parameter int NB_SHAMT      = 5
) (
    input logic          i_clock,
    input logic          i_reset,
    ex_alu_iter_if.slave alu
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] SH_LEFT   = 2'd0;
    localparam logic [1:0] SH_LRIGHT = 2'd1;
    localparam logic [1:0] SH_ARIGHT = 2'd2;

    localparam logic [NB_ALU_OPCODE-1:0] OP_SLL  = NB_ALU_OPCODE'(4'b0000);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SRAV = NB_ALU_OPCODE'(4'b0001);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SRL  = NB_ALU_OPCODE'(4'b0010);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SRA  = NB_ALU_OPCODE'(4'b0011);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SRLV = NB_ALU_OPCODE'(4'b0110);
    localparam logic [NB_ALU_OPCODE-1:0] OP_NOR  = NB_ALU_OPCODE'(4'b0111);
    localparam logic [NB_ALU_OPCODE-1:0] OP_ADD  = NB_ALU_OPCODE'(4'b1000);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SLT  = NB_ALU_OPCODE'(4'b1001);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SLLV = NB_ALU_OPCODE'(4'b1010);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SUB  = NB_ALU_OPCODE'(4'b1011);
    localparam logic [NB_ALU_OPCODE-1:0] OP_AND  = NB_ALU_OPCODE'(4'b1100);
    localparam logic [NB_ALU_OPCODE-1:0] OP_OR   = NB_ALU_OPCODE'(4'b1101);
    localparam logic [NB_ALU_OPCODE-1:0] OP_XOR  = NB_ALU_OPCODE'(4'b1110);
    localparam logic [NB_ALU_OPCODE-1:0] OP_LUI  = NB_ALU_OPCODE'(4'b1111);

    logic [1:0]          state_reg;
    logic [1:0]          kind_reg;
    logic [NB_SHAMT-1:0] count_reg;
    logic [NB_DATA-1:0]  work_reg;
    logic [NB_DATA-1:0]  result_reg;

    logic [NB_DATA-1:0]  op_a;
    logic [NB_DATA-1:0]  op_b;
    logic [NB_SHAMT-1:0] shift_amt;
    logic                is_shift;
    logic [1:0]          shift_kind;
    logic [NB_DATA-1:0]  alu_result;
    logic [NB_DATA-1:0]  load_result;
    logic [NB_DATA-1:0]  work_next;
    logic                accept;

    always_comb begin
        op_a        = alu.i_first_ope_rt ? alu.i_rt_data : alu.i_rs_data;
        op_b        = alu.i_use_imm ? alu.i_imm : alu.i_rt_data;
        shift_amt   = alu.i_second_ope_sa ? alu.i_shamt :
                      alu.i_second_ope_rs ? alu.i_rs_data[NB_SHAMT-1:0] : '0;
        is_shift    = 1'b0;
        shift_kind  = SH_LEFT;
        alu_result  = '0;
        case (alu.i_alu_opcode)
            OP_SLL, OP_SLLV: begin is_shift = 1'b1; shift_kind = SH_LEFT;   end
            OP_SRL, OP_SRLV: begin is_shift = 1'b1; shift_kind = SH_LRIGHT; end
            OP_SRA, OP_SRAV: begin is_shift = 1'b1; shift_kind = SH_ARIGHT; end
            OP_ADD: alu_result = op_a + op_b;
            OP_SUB: alu_result = op_a - op_b;
            OP_AND: alu_result = op_a & op_b;
            OP_OR:  alu_result = op_a | op_b;
            OP_XOR: alu_result = op_a ^ op_b;
            OP_NOR: alu_result = ~(op_a | op_b);
            OP_SLT: alu_result = ($signed(op_a) < $signed(op_b)) ? NB_DATA'(1) : '0;
            OP_LUI: alu_result = op_b << 16;
            default: alu_result = '0;
        endcase
        // A zero-amount shift is just a pass-through of operand A.
        load_result = is_shift ? op_a : alu_result;
    end

    always_comb begin
        case (kind_reg)
            SH_LEFT:   work_next = {work_reg[NB_DATA-2:0], 1'b0};
            SH_LRIGHT: work_next = {1'b0, work_reg[NB_DATA-1:1]};
            default:   work_next = {work_reg[NB_DATA-1], work_reg[NB_DATA-1:1]};
        endcase
    end

    assign accept = alu.i_valid && alu.o_ready && !alu.i_flush;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_reg  <= IDLE;
            kind_reg   <= SH_LEFT;
            count_reg  <= '0;
            work_reg   <= '0;
            result_reg <= '0;
        end else if (alu.i_flush) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                SHIFT: begin
                    work_reg  <= work_next;
                    count_reg <= count_reg - NB_SHAMT'(1);
                    if (count_reg == NB_SHAMT'(1)) begin
                        state_reg  <= DONE;
                        result_reg <= work_next;
                    end
                end
                default: begin
                    // IDLE and DONE accept identically so DONE can chain back-to-back.
                    if (accept) begin
                        if (is_shift && shift_amt != '0) begin
                            state_reg <= SHIFT;
                            work_reg  <= op_a;
                            count_reg <= shift_amt;
                            kind_reg  <= shift_kind;
                        end else begin
                            state_reg  <= DONE;
                            result_reg <= load_result;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign alu.o_ready  = (state_reg != SHIFT);
    assign alu.o_valid  = (state_reg == DONE);
    assign alu.o_result = result_reg;
    assign alu.o_zero   = (result_reg == '0);
endmodule

// File: tb/tb_ex_alu_iter.sv
// Directed checks of ex_alu_iter: arithmetic/logic results, iterative shift
// latency, flush and reset behaviour, back-to-back throughput.
module tb_ex_alu_iter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ex_alu_iter_if #(.NB_DATA(32), .NB_ALU_OPCODE(4), .NB_SHAMT(5)) bus ();

    ex_alu_iter #(.NB_DATA(32), .NB_ALU_OPCODE(4), .NB_SHAMT(5)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .alu     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic use_imm, input logic [4:0] sh,
                         input logic f_sa, input logic f_rs, input logic f_rt);
        bus.i_alu_opcode    = op;
        bus.i_rs_data       = rs;
        bus.i_rt_data       = rt;
        bus.i_imm           = imm;
        bus.i_use_imm       = use_imm;
        bus.i_shamt         = sh;
        bus.i_second_ope_sa = f_sa;
        bus.i_second_ope_rs = f_rs;
        bus.i_first_ope_rt  = f_rt;
        bus.i_valid         = 1'b1;
        step();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_alu_opcode = '0;
        bus.i_second_ope_sa = 1'b0; bus.i_second_ope_rs = 1'b0; bus.i_first_ope_rt = 1'b0;
        bus.i_rs_data = '0; bus.i_rt_data = '0; bus.i_imm = '0; bus.i_use_imm = 1'b0;
        bus.i_shamt = '0;

        // Reset
        step(); step();
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_result", bus.o_result, 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_zero", 32'(bus.o_zero), 32'd1);
        check("idle_valid", 32'(bus.o_valid), 32'd0);

        // ADD with immediate: 5 + (-3) = 2
        issue(4'b1000, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("add_valid", 32'(bus.o_valid), 32'd1);
        check("add_result", bus.o_result, 32'd2);
        check("add_zero", 32'(bus.o_zero), 32'd0);
        step();
        check("add_strobe", 32'(bus.o_valid), 32'd0);
        check("add_hold", bus.o_result, 32'd2);

        // SUB equal operands, then SLT signed
        issue(4'b1011, 32'd7, 32'd7, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sub_result", bus.o_result, 32'd0);
        check("sub_zero", 32'(bus.o_zero), 32'd1);
        issue(4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("slt_result", bus.o_result, 32'd1);

        // NOR, LUI, undefined opcode
        issue(4'b0111, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("nor_result", bus.o_result, 32'hF000_F000);
        issue(4'b1111, 32'd0, 32'd0, 32'h0000_1234, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lui_result", bus.o_result, 32'h1234_0000);
        issue(4'b0100, 32'd9, 32'd9, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("undef_valid", 32'(bus.o_valid), 32'd1);
        check("undef_result", bus.o_result, 32'd0);

        // SRA rt=0x80000000 by 4: ready low 4 cycles, valid on the 5th
        issue(4'b0011, 32'd0, 32'h8000_0000, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("sra_busy", 32'(bus.o_ready), 32'd0);
            check("sra_novalid", 32'(bus.o_valid), 32'd0);
            step();
        end
        check("sra_valid", 32'(bus.o_valid), 32'd1);
        check("sra_result", bus.o_result, 32'hF800_0000);
        check("sra_ready", 32'(bus.o_ready), 32'd1);

        // SLLV with amount rs[4:0]=0 completes in one cycle
        issue(4'b1010, 32'h0000_0020, 32'd1, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("sllv_valid", 32'(bus.o_valid), 32'd1);
        check("sllv_result", bus.o_result, 32'd1);

        // SRL by 31, flushed at cycle 10
        issue(4'b0010, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 10; i++) begin
            check("srl_busy", 32'(bus.o_ready), 32'd0);
            step();
        end
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        check("flush_ready", 32'(bus.o_ready), 32'd1);
        check("flush_valid", 32'(bus.o_valid), 32'd0);
        check("flush_result", bus.o_result, 32'd1);
        step();
        check("flush_quiet", 32'(bus.o_valid), 32'd0);
        issue(4'b1000, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("post_add_vld", 32'(bus.o_valid), 32'd1);
        check("post_add_res", bus.o_result, 32'd7);

        // Flush beats i_valid in the same cycle
        bus.i_rs_data = 32'd10; bus.i_rt_data = 32'd10;
        bus.i_valid = 1'b1; bus.i_flush = 1'b1;
        step();
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        check("fprio_valid", 32'(bus.o_valid), 32'd0);
        check("fprio_result", bus.o_result, 32'd7);
        step();
        check("fprio_late", 32'(bus.o_valid), 32'd0);

        // Back-to-back ADD, OR, XOR
        bus.i_alu_opcode = 4'b1000; bus.i_rs_data = 32'd1; bus.i_rt_data = 32'd2;
        bus.i_valid = 1'b1;
        step();
        check("b2b_add_vld", 32'(bus.o_valid), 32'd1);
        check("b2b_add_res", bus.o_result, 32'd3);
        bus.i_alu_opcode = 4'b1101; bus.i_rs_data = 32'h0000_00F0; bus.i_rt_data = 32'h0000_000F;
        step();
        check("b2b_or_vld", 32'(bus.o_valid), 32'd1);
        check("b2b_or_res", bus.o_result, 32'h0000_00FF);
        bus.i_alu_opcode = 4'b1110; bus.i_rs_data = 32'h0000_00FF; bus.i_rt_data = 32'h0000_000F;
        step();
        bus.i_valid = 1'b0;
        check("b2b_xor_vld", 32'(bus.o_valid), 32'd1);
        check("b2b_xor_res", bus.o_result, 32'h0000_00F0);
        step();
        check("b2b_end", 32'(bus.o_valid), 32'd0);

        // Reset in the middle of SLL by 5 discards the operation
        issue(4'b0000, 32'd0, 32'd1, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_valid", 32'(bus.o_valid), 32'd0);
        check("mrst_result", bus.o_result, 32'd0);
        check("mrst_ready", 32'(bus.o_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("mrst_quiet", 32'(bus.o_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
